// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: tracks in-flight destinations after decode, selects forwarded
// operands and raises a stall while the youngest producer of a source is not yet forwardable.
module pipe_hazard_unit #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int ALU_RDY  = 1,
    parameter int LOAD_RDY = 2,
    parameter int SW       = $clog2(DEPTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_src1,
    input  logic [REG_AW-1:0]       id_src2,
    input  logic                    id_use1,
    input  logic                    id_use2,
    input  logic [REG_AW-1:0]       id_dest,
    input  logic                    id_wb,
    input  logic                    id_mem_read,
    input  logic                    flush,
    input  logic [DATA_W-1:0]       reg1,
    input  logic [DATA_W-1:0]       reg2,
    input  logic [DEPTH*DATA_W-1:0] stage_result,
    output logic                    stall,
    output logic [SW-1:0]           fwd_sel1,
    output logic [SW-1:0]           fwd_sel2,
    output logic [DATA_W-1:0]       operand1,
    output logic [DATA_W-1:0]       operand2,
    output logic [15:0]             stall_count
);

    logic [DEPTH-1:0]  ent_valid, ent_wb, ent_mr;
    logic [REG_AW-1:0] ent_dest [DEPTH];
    logic [REG_AW-1:0] src [2];
    logic [1:0]        use_src, hit, rdy, from_load;
    logic [SW-1:0]     idx [2];
    logic [SW-1:0]     sel [2];
    logic [DATA_W-1:0] rf [2];
    logic [DATA_W-1:0] opnd [2];

    assign src[0]   = id_src1;
    assign src[1]   = id_src2;
    assign use_src  = {id_use2, id_use1};
    assign rf[0]    = reg1;
    assign rf[1]    = reg2;
    assign fwd_sel1 = sel[0];
    assign fwd_sel2 = sel[1];
    assign operand1 = opnd[0];
    assign operand2 = opnd[1];
    assign stall    = id_valid & ~flush & |(hit & ~rdy);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hit[s]       = 1'b0;
            idx[s]       = '0;
            from_load[s] = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (use_src[s] && src[s] != '0 && ent_valid[k] && ent_wb[k] && ent_dest[k] == src[s]) begin
                    hit[s]       = 1'b1;
                    idx[s]       = SW'(k);
                    from_load[s] = ent_mr[k];
                end
            end
            rdy[s]  = idx[s] >= (from_load[s] ? SW'(LOAD_RDY) : SW'(ALU_RDY));
            sel[s]  = (hit[s] && rdy[s]) ? idx[s] + SW'(1) : '0;
            opnd[s] = (hit[s] && rdy[s]) ? stage_result[idx[s]*DATA_W +: DATA_W] : rf[s];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ent_valid   <= '0;
            ent_wb      <= '0;
            ent_mr      <= '0;
            stall_count <= '0;
            for (int k = 0; k < DEPTH; k++) ent_dest[k] <= '0;
        end else begin
            ent_valid   <= {ent_valid[DEPTH-2:0], id_valid & ~stall & ~flush};
            ent_wb      <= {ent_wb[DEPTH-2:0], id_wb};
            ent_mr      <= {ent_mr[DEPTH-2:0], id_mem_read};
            ent_dest[0] <= id_dest;
            for (int k = 1; k < DEPTH; k++) ent_dest[k] <= ent_dest[k-1];
            if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed hazard scenarios with a queued scoreboard checked at negedge;
// a second deep instance drives the stall counter into saturation.
module tb_pipe_hazard_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, id_valid, id_use1, id_use2, id_wb, id_mem_read, flush;
    logic [4:0]  id_src1, id_src2, id_dest;
    logic [31:0] reg1, reg2;
    logic [31:0] sr_v [3];
    logic [95:0] stage_result;
    logic        stall;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic [31:0] operand1, operand2;
    logic [15:0] stall_count;

    logic        s_reset_n, s_stall;
    logic [3:0]  s_sel1, s_sel2;
    logic [31:0] s_op1, s_op2;
    logic [15:0] s_count;

    assign sr_v[0] = 32'hA0A0_0000;
    assign sr_v[1] = 32'hB1B1_1111;
    assign sr_v[2] = 32'hC2C2_2222;
    assign stage_result = {sr_v[2], sr_v[1], sr_v[0]};
    assign reg1 = 32'h1111_0001;
    assign reg2 = 32'h2222_0002;

    pipe_hazard_unit dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
        .id_dest(id_dest), .id_wb(id_wb), .id_mem_read(id_mem_read), .flush(flush),
        .reg1(reg1), .reg2(reg2), .stage_result(stage_result), .stall(stall),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .operand1(operand1), .operand2(operand2),
        .stall_count(stall_count)
    );

    // Deep load latency: a self-dependent load stream stalls 7 of every 8 cycles.
    pipe_hazard_unit #(.DEPTH(8), .ALU_RDY(1), .LOAD_RDY(7)) sat (
        .clock(clock), .reset_n(s_reset_n), .id_valid(1'b1),
        .id_src1(5'd3), .id_src2(5'd0), .id_use1(1'b1), .id_use2(1'b0),
        .id_dest(5'd3), .id_wb(1'b1), .id_mem_read(1'b1), .flush(1'b0),
        .reg1(32'd0), .reg2(32'd0), .stage_result('0), .stall(s_stall),
        .fwd_sel1(s_sel1), .fwd_sel2(s_sel2), .operand1(s_op1), .operand2(s_op2),
        .stall_count(s_count)
    );

    typedef struct {
        string       name;
        int          which;
        int          stall;
        int          sel1;
        int          sel2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [15:0] cnt;
    } exp_t;

    exp_t q [$];
    int tests = 0;
    int fails = 0;

    task automatic chk(string n, string f, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %0h expected %0h", n, f, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.which == 0) begin
                chk(e.name, "stall", 32'(stall), 32'(e.stall));
                chk(e.name, "fwd_sel1", 32'(fwd_sel1), 32'(e.sel1));
                chk(e.name, "fwd_sel2", 32'(fwd_sel2), 32'(e.sel2));
                chk(e.name, "operand1", operand1, e.op1);
                chk(e.name, "operand2", operand2, e.op2);
                chk(e.name, "stall_count", 32'(stall_count), 32'(e.cnt));
            end else begin
                if (e.stall >= 0) chk(e.name, "stall", 32'(s_stall), 32'(e.stall));
                chk(e.name, "stall_count", 32'(s_count), 32'(e.cnt));
            end
        end
    end

    task automatic expect_main(string n, int st, int s1, int s2, logic [15:0] c);
        exp_t e;
        e.name = n; e.which = 0; e.stall = st; e.sel1 = s1; e.sel2 = s2; e.cnt = c;
        e.op1 = (s1 == 0) ? reg1 : sr_v[s1-1];
        e.op2 = (s2 == 0) ? reg2 : sr_v[s2-1];
        q.push_back(e);
    endtask

    task automatic expect_sat(string n, int st, logic [15:0] c);
        exp_t e;
        e.name = n; e.which = 1; e.stall = st; e.sel1 = 0; e.sel2 = 0; e.cnt = c;
        e.op1 = '0; e.op2 = '0;
        q.push_back(e);
    endtask

    task automatic drive(logic v, logic [4:0] s1, logic u1, logic [4:0] s2, logic u2,
                         logic [4:0] d, logic w, logic m, logic f);
        id_valid = v; id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
        id_dest = d; id_wb = w; id_mem_read = m; flush = f;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        s_reset_n = 1'b0;
        idle();
        tick();
        // Reset with a hazard-shaped decode: nothing tracked, so nothing stalls.
        drive(1, 5, 1, 6, 1, 5, 1, 1, 0); expect_main("rst_hold", 0, 0, 0, 0); tick();
        reset_n = 1'b1;
        idle();                              expect_main("rst_idle", 0, 0, 0, 0); tick();
        // ALU back-to-back
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);    expect_main("alu_issue", 0, 0, 0, 0); tick();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);    expect_main("alu_stall", 1, 0, 0, 0); tick();
                                             expect_main("alu_fwd", 0, 2, 0, 1); tick();
        idle();                              expect_main("alu_after", 0, 0, 0, 1); tick();
        do_reset();
        // Load-use
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);    expect_main("ld_issue", 0, 0, 0, 0); tick();
        drive(1, 0, 0, 7, 1, 9, 1, 0, 0);    expect_main("ld_stall0", 1, 0, 0, 0); tick();
                                             expect_main("ld_stall1", 1, 0, 0, 1); tick();
                                             expect_main("ld_fwd", 0, 0, 3, 2); tick();
        // Youngest match wins, first while unusable then while forwardable
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0);    expect_main("yw_p1", 0, 0, 0, 2); tick();
                                             expect_main("yw_p2", 0, 0, 0, 2); tick();
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0);    expect_main("yw_stall", 1, 0, 0, 2); tick();
                                             expect_main("yw_fwd", 0, 2, 0, 3); tick();
        // Register 0 and unused source
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0);    expect_main("r0_issue", 0, 0, 0, 3); tick();
        drive(1, 0, 1, 0, 1, 6, 1, 1, 0);    expect_main("r0_src", 0, 0, 0, 3); tick();
        drive(1, 0, 0, 6, 0, 0, 0, 0, 0);    expect_main("unused_src", 0, 0, 0, 3); tick();
        // Invalid decode slot never stalls
        drive(1, 0, 0, 0, 0, 11, 1, 1, 0);   expect_main("inv_issue", 0, 0, 0, 3); tick();
        drive(0, 11, 1, 0, 0, 0, 0, 0, 0);   expect_main("inv_nostall", 0, 0, 0, 3); tick();
        // Flush beats stall and injects a bubble
        drive(1, 0, 0, 0, 0, 8, 1, 1, 0);    expect_main("fl_issue", 0, 0, 0, 3); tick();
        drive(1, 8, 1, 0, 0, 10, 1, 0, 1);   expect_main("fl_flush", 0, 0, 0, 3); tick();
        drive(1, 10, 1, 0, 0, 0, 0, 0, 0);   expect_main("fl_bubble", 0, 0, 0, 3); tick();
        // Reset in the middle of a stall
        drive(1, 0, 0, 0, 0, 12, 1, 1, 0);   expect_main("rs_issue", 0, 0, 0, 3); tick();
        drive(1, 12, 1, 0, 0, 0, 0, 0, 0);   expect_main("rs_stall", 1, 0, 0, 3);
        reset_n = 1'b0; tick();
                                             expect_main("rs_clear", 0, 0, 0, 0);
        reset_n = 1'b1; tick();
        idle();                              expect_main("rs_after", 0, 0, 0, 0); tick();
        // Saturation on the deep instance
        s_reset_n = 1'b1;
        repeat (75000) tick();
        expect_sat("sat_max", -1, 16'hFFFF); tick();
        s_reset_n = 1'b0; tick();
        expect_sat("sat_rst", 0, 16'h0000);
        s_reset_n = 1'b1; tick();
        tick();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
